// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions: RV32 major-opcode constants used by the hazard
// logic, the hazard-controller FSM state type, and register-field helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_e;

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/hz_src_use.sv
// -----------------------------------------------------------------------------
// hz_src_use
// Decodes which source-register fields of an instruction are real operands.
// rs1 is read by everything except LUI, AUIPC and JAL; rs2 only by R-type,
// STORE and BRANCH. Purely combinational.
// Ports:
//   inst     in  32  instruction word
//   rs1_used out 1   rs1 field is an operand
//   rs2_used out 1   rs2 field is an operand
// -----------------------------------------------------------------------------
module hz_src_use
  import pipeline_pkg::*;
(
  input  logic [31:0] inst,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opcode;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  // Only the opcode matters for operand usage.
  assign unused_inst_bits = ^inst[31:7];

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:     rs1_used = 1'b0;
      OPC_RTYPE, OPC_STORE, OPC_BRANCH: rs2_used = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use bubbles, branch flushes and LSU wait
// stalls with a watchdog. Priority: LSU wait > branch taken > load-use.
// Outputs are combinational from the current state and inputs.
// Optional feature: define HAZARD_STALL_CNT_EN to add o_hz_stall_cycles, a
// free-running 32-bit count of cycles with any stall asserted.
// Parameter:
//   MEM_TIMEOUT  max MEM_WAIT cycles before forced release (0 = no watchdog)
// Ports:
//   i_clk, i_reset (sync, active-high)
//   i_hz_inst_decode[31:0]     instruction in ID
//   i_hz_rd_addr_execute[4:0]  rd of the instruction in EX
//   i_hz_mem_rden_execute      EX holds a load
//   i_hz_branch_taken_execute  redirect resolved in EX
//   i_hz_lsu_req_mem           MEM instruction uses the LSU
//   i_hz_lsu_ack               LSU completes this cycle
//   o_hz_stall_pc/if_id/id_ex/ex_mem  hold signals
//   o_hz_flush_if_id/id_ex     bubble insertion
//   o_hz_state[1:0]            current FSM state
//   o_hz_mem_timeout           one-cycle watchdog expiry pulse
//   o_hz_stall_cycles[31:0]    (HAZARD_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
)(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_hz_inst_decode,
  input  logic [4:0]  i_hz_rd_addr_execute,
  input  logic        i_hz_mem_rden_execute,
  input  logic        i_hz_branch_taken_execute,
  input  logic        i_hz_lsu_req_mem,
  input  logic        i_hz_lsu_ack,
  output logic        o_hz_stall_pc,
  output logic        o_hz_stall_if_id,
  output logic        o_hz_stall_id_ex,
  output logic        o_hz_stall_ex_mem,
  output logic        o_hz_flush_if_id,
  output logic        o_hz_flush_id_ex,
  output logic [1:0]  o_hz_state,
  output logic        o_hz_mem_timeout
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] o_hz_stall_cycles
`endif
);

  localparam bit           TMO_EN   = (MEM_TIMEOUT != 0);
  localparam int           WD_W     = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

  hz_state_e       state_reg, state_next;
  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

  logic rs1_used, rs2_used;
  logic [4:0] rs1, rs2;
  logic mem_wait_cond;
  logic load_use;
  logic load_use_en;

  hz_src_use u_src_use (
    .inst     (i_hz_inst_decode),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign rs1 = rs1_of(i_hz_inst_decode);
  assign rs2 = rs2_of(i_hz_inst_decode);

  assign mem_wait_cond = i_hz_lsu_req_mem & ~i_hz_lsu_ack;

  assign load_use = i_hz_mem_rden_execute
                  && (i_hz_rd_addr_execute != 5'd0)
                  && ((rs1_used && (i_hz_rd_addr_execute == rs1))
                   || (rs2_used && (i_hz_rd_addr_execute == rs2)));

  // LOAD_STALL masks detection so one load yields one bubble; in FLUSH the
  // ID stage holds a squashed instruction, so nothing there can be a consumer.
  assign load_use_en = (state_reg == RUN) || (state_reg == MEM_WAIT);

  always_comb begin
    state_next        = RUN;
    wd_cnt_next       = '0;
    o_hz_stall_pc     = 1'b0;
    o_hz_stall_if_id  = 1'b0;
    o_hz_stall_id_ex  = 1'b0;
    o_hz_stall_ex_mem = 1'b0;
    o_hz_flush_if_id  = 1'b0;
    o_hz_flush_id_ex  = 1'b0;
    o_hz_mem_timeout  = 1'b0;

    if (i_reset) begin
      state_next = RUN;
    end else if (mem_wait_cond) begin
      if (TMO_EN && (state_reg == MEM_WAIT) && (wd_cnt_reg == WD_LIMIT)) begin
        // Watchdog expiry: release the pipeline for one cycle and restart.
        o_hz_mem_timeout = 1'b1;
        state_next       = RUN;
      end else begin
        o_hz_stall_pc     = 1'b1;
        o_hz_stall_if_id  = 1'b1;
        o_hz_stall_id_ex  = 1'b1;
        o_hz_stall_ex_mem = 1'b1;
        state_next        = MEM_WAIT;
        // The count starts at the first cycle spent in MEM_WAIT.
        if (state_reg == MEM_WAIT) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
    end else if (i_hz_branch_taken_execute) begin
      // Decode holds a wrong-path instruction, so a load-use match is moot.
      o_hz_flush_if_id = 1'b1;
      o_hz_flush_id_ex = 1'b1;
      state_next       = FLUSH;
    end else if (load_use && load_use_en) begin
      o_hz_stall_pc    = 1'b1;
      o_hz_stall_if_id = 1'b1;
      o_hz_flush_id_ex = 1'b1;
      state_next       = LOAD_STALL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= RUN;
      wd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  assign o_hz_state = state_reg;

`ifdef HAZARD_STALL_CNT_EN
  logic        stall_any;
  logic [31:0] stall_cycles_reg;

  assign stall_any = o_hz_stall_pc | o_hz_stall_if_id
                   | o_hz_stall_id_ex | o_hz_stall_ex_mem;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cycles_reg <= '0;
    end else if (stall_any) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign o_hz_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic for hazard_ctrl built with
// a 3-cycle watchdog. Output vector order used throughout:
//   {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
//    flush_id_ex, mem_timeout}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TMO = 3;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [4:0]  rd;
  logic        rden;
  logic        br;
  logic        req;
  logic        ack;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic        flush_if_id, flush_id_ex;
  logic [1:0]  hz_state;
  logic        mem_timeout;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [6:0] out_vec;
  assign out_vec = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                    flush_if_id, flush_id_ex, mem_timeout};

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state;
  int          m_wd;
  logic [31:0] m_cycles;

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .i_clk                     (clk),
    .i_reset                   (rst),
    .i_hz_inst_decode          (inst),
    .i_hz_rd_addr_execute      (rd),
    .i_hz_mem_rden_execute     (rden),
    .i_hz_branch_taken_execute (br),
    .i_hz_lsu_req_mem          (req),
    .i_hz_lsu_ack              (ack),
    .o_hz_stall_pc             (stall_pc),
    .o_hz_stall_if_id          (stall_if_id),
    .o_hz_stall_id_ex          (stall_id_ex),
    .o_hz_stall_ex_mem         (stall_ex_mem),
    .o_hz_flush_if_id          (flush_if_id),
    .o_hz_flush_id_ex          (flush_id_ex),
    .o_hz_state                (hz_state),
    .o_hz_mem_timeout          (mem_timeout)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .o_hz_stall_cycles         (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle against constant expectations, then advance past the edge.
  task automatic exp_cyc(input string tag, input logic [6:0] ev, input logic [1:0] es);
    @(negedge clk);
    chk({tag, ".out"}, 32'(out_vec), 32'(ev));
    chk({tag, ".state"}, 32'(hz_state), 32'(es));
    $display("[%0t] %s out=%b state=%0d", $time, tag, out_vec, hz_state);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic [31:0] i, input logic [4:0] d,
                        input logic ld, input logic b, input logic q, input logic a);
    rst = r; inst = i; rd = d; rden = ld; br = b; req = q; ack = a;
  endtask

  // Behavioural model: event priority wait > branch > load-use, evaluated on
  // the current inputs and the model's notion of the current state.
  function automatic void model_eval(output logic [6:0] ev, output int ns, output int nw);
    logic [6:0] op;
    logic r1u, r2u, hz, wait_c;
    op     = inst[6:0];
    r1u    = !(op inside {7'h37, 7'h17, 7'h6F});
    r2u    = (op inside {7'h33, 7'h23, 7'h63});
    hz     = rden && (rd != 5'd0) &&
             ((r1u && rd == inst[19:15]) || (r2u && rd == inst[24:20]));
    wait_c = req && !ack;
    ev = 7'b0; ns = 0; nw = 0;
    if (rst) begin
      ev = 7'b0;
    end else if (wait_c && m_state == 3 && TMO != 0 && m_wd == TMO) begin
      ev = 7'b0000001;
    end else if (wait_c) begin
      ev = 7'b1111000; ns = 3; nw = (m_state == 3) ? m_wd + 1 : 0;
    end else if (br) begin
      ev = 7'b0000110; ns = 2;
    end else if (hz && (m_state == 0 || m_state == 3)) begin
      ev = 7'b1100010; ns = 1;
    end
  endfunction

  localparam logic [31:0] ADD_X1_X5_X6 = 32'h006280B3;
  localparam logic [31:0] LUI_X5_1     = 32'h000012B7;
  localparam logic [31:0] LUI_X1_28    = 32'h000280B7; // rs1 field = 5
  localparam logic [31:0] ADD_X1_X0_X0 = 32'h000000B3;
  localparam logic [31:0] ADDI_X1_X0_5 = 32'h00500093; // rs2 field = 5
  localparam logic [31:0] SW_X5        = 32'h00502023;

  initial begin
    logic [6:0]  ev;
    int          ns, nw;
    logic [31:0] ri;
    logic [6:0]  ops [9];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h33, 7'h23, 7'h63, 7'h03, 7'h13, 7'h67};

    // Reset with every event input active: outputs must stay quiet.
    set_in(1, ADD_X1_X5_X6, 5, 1, 1, 1, 0);
    @(posedge clk); #1;
    exp_cyc("reset", 7'b0, 2'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("reset.cnt", stall_cycles, 32'd0);
`endif
    set_in(0, 32'h13, 0, 0, 0, 0, 0);
    exp_cyc("idle", 7'b0, 2'd0);

    // Load-use: one bubble, detection masked while in LOAD_STALL.
    set_in(0, ADD_X1_X5_X6, 5, 1, 0, 0, 0);
    exp_cyc("lu.c1", 7'b1100010, 2'd0);
    exp_cyc("lu.c2", 7'b0, 2'd1);
    rden = 0;
    exp_cyc("lu.c3", 7'b0, 2'd0);

    // Unused / x0 operands.
    set_in(0, LUI_X5_1, 5, 1, 0, 0, 0);
    exp_cyc("lui1", 7'b0, 2'd0);
    inst = LUI_X1_28;
    exp_cyc("lui_rs1f", 7'b0, 2'd0);
    inst = ADDI_X1_X0_5;
    exp_cyc("addi_rs2f", 7'b0, 2'd0);
    set_in(0, ADD_X1_X0_X0, 0, 1, 0, 0, 0);
    exp_cyc("x0", 7'b0, 2'd0);
    set_in(0, SW_X5, 5, 1, 0, 0, 0);
    exp_cyc("sw_rs2", 7'b1100010, 2'd0);
    rden = 0;
    exp_cyc("sw_rs2.c2", 7'b0, 2'd1);

    // Branch beats load-use.
    set_in(0, ADD_X1_X5_X6, 5, 1, 1, 0, 0);
    exp_cyc("br.c1", 7'b0000110, 2'd0);
    set_in(0, 32'h13, 0, 0, 0, 0, 0);
    exp_cyc("br.c2", 7'b0, 2'd2);
    exp_cyc("br.c3", 7'b0, 2'd0);

    // LSU wait of four cycles, released by ack.
    set_in(0, 32'h13, 0, 0, 0, 1, 0);
    exp_cyc("mw.c1", 7'b1111000, 2'd0);
    exp_cyc("mw.c2", 7'b1111000, 2'd3);
    exp_cyc("mw.c3", 7'b1111000, 2'd3);
    exp_cyc("mw.c4", 7'b1111000, 2'd3);
    ack = 1;
    exp_cyc("mw.ack", 7'b0, 2'd3);
    set_in(0, 32'h13, 0, 0, 0, 0, 0);
    exp_cyc("mw.post", 7'b0, 2'd0);

    // Watchdog: pulse on the 4th MEM_WAIT cycle.
    req = 1;
    exp_cyc("to.c1", 7'b1111000, 2'd0);
    exp_cyc("to.w1", 7'b1111000, 2'd3);
    exp_cyc("to.w2", 7'b1111000, 2'd3);
    exp_cyc("to.w3", 7'b1111000, 2'd3);
    exp_cyc("to.w4", 7'b0000001, 2'd3);
    req = 0;
    exp_cyc("to.post", 7'b0, 2'd0);

    // Branch during a wait is deferred to the release cycle.
    set_in(0, 32'h13, 0, 0, 1, 1, 0);
    exp_cyc("mwbr.c1", 7'b1111000, 2'd0);
    exp_cyc("mwbr.c2", 7'b1111000, 2'd3);
    ack = 1;
    exp_cyc("mwbr.rel", 7'b0000110, 2'd3);
    set_in(0, 32'h13, 0, 0, 0, 0, 0);
    exp_cyc("mwbr.fl", 7'b0, 2'd2);

    // Reset abandons a wait without a timeout pulse.
    set_in(0, 32'h13, 0, 0, 0, 1, 0);
    exp_cyc("rmw.c1", 7'b1111000, 2'd0);
    exp_cyc("rmw.c2", 7'b1111000, 2'd3);
    rst = 1;
    exp_cyc("rmw.rst", 7'b0, 2'd3);
    exp_cyc("rmw.rst2", 7'b0, 2'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rmw.cnt", stall_cycles, 32'd0);
`endif
    set_in(0, 32'h13, 0, 0, 0, 0, 0);
    exp_cyc("rmw.post", 7'b0, 2'd0);

    // Randomized traffic against the model. A reset precedes it so that the
    // model and DUT start from the same known point.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_state = 0; m_wd = 0; m_cycles = 32'd0;
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 8)];
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      inst = ri;
      rd   = 5'($urandom_range(0, 7));
      rden = ($urandom_range(0, 99) < 50);
      br   = ($urandom_range(0, 99) < 15);
      req  = req ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
      ack  = ($urandom_range(0, 99) < 20);
      rst  = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      model_eval(ev, ns, nw);
      chk("rnd.out", 32'(out_vec), 32'(ev));
      chk("rnd.state", 32'(hz_state), 32'(m_state));
`ifdef HAZARD_STALL_CNT_EN
      chk("rnd.cnt", stall_cycles, m_cycles);
`endif
      $display("[%0t] rnd %0d rst=%b req=%b ack=%b br=%b ld=%b out=%b state=%0d",
               $time, n, rst, req, ack, br, rden, out_vec, hz_state);
      @(posedge clk);
      if (rst) m_cycles = 32'd0;
      else if (|ev[6:3]) m_cycles = m_cycles + 32'd1;
      m_state = ns;
      m_wd    = nw;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
